// File: rtl/ieu_fwd_pipe.sv
// Integer result pipeline: in-order retire to a register file, late fill for pending results, operand read ports.
// Macro IEU_FWD_PIPE_BYPASS_EN compiles in forwarding; without it any in-flight match reports a hazard.
module ieu_fwd_pipe #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 3,
    parameter int NREAD = 2,
    parameter int NREGS = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       IssueValid,
    input  logic [4:0]                 IssueRd,
    input  logic [XLEN-1:0]            IssueData,
    input  logic                       IssuePending,
    output logic                       IssueReady,
    input  logic                       Stall,
    input  logic [DEPTH-1:0]           FlushMask,
    input  logic                       FillValid,
    input  logic [$clog2(DEPTH)-1:0]   FillStage,
    input  logic [XLEN-1:0]            FillData,
    input  logic [NREAD*5-1:0]         RsAddr,
    output logic [NREAD*XLEN-1:0]      RsData,
    output logic [NREAD-1:0]           RsHazard,
    output logic                       RetireStall,
    output logic                       WbValid,
    output logic [4:0]                 WbRd,
    output logic [XLEN-1:0]            WbData
);

    localparam int FW = $clog2(DEPTH);
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    logic [DEPTH-1:0] st_v;
    logic [DEPTH-1:0] st_p;
    logic [4:0]       st_rd [DEPTH];
    logic [XLEN-1:0]  st_d  [DEPTH];
    logic [XLEN-1:0]  rf    [32];

    logic             adv;
    logic [DEPTH-1:0] nx_v;
    logic [DEPTH-1:0] nx_p;
    logic [XLEN-1:0]  nx_d  [DEPTH];

    function automatic logic rd_ok(input logic [4:0] r);
        return (r != 5'd0) && ({1'b0, r} < NREGS_L);
    endfunction

    assign RetireStall = st_v[DEPTH-1] & st_p[DEPTH-1];
    assign adv         = ~Stall & ~RetireStall;
    assign IssueReady  = adv;
    assign WbValid     = st_v[DEPTH-1] & ~st_p[DEPTH-1] & adv & rd_ok(st_rd[DEPTH-1]);
    assign WbRd        = st_rd[DEPTH-1];
    assign WbData      = st_d[DEPTH-1];

    // Per-stage view after this edge's flush and fill; flush masks out the fill.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nx_v[i] = st_v[i] & ~FlushMask[i];
            nx_p[i] = st_p[i];
            nx_d[i] = st_d[i];
            if (nx_v[i] && st_p[i] && FillValid && (FillStage == FW'(i))) begin
                nx_p[i] = 1'b0;
                nx_d[i] = FillData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_v <= '0;
            st_p <= '0;
        end else if (adv) begin
            st_v <= {nx_v[DEPTH-2:0], IssueValid};
            st_p <= {nx_p[DEPTH-2:0], IssuePending};
        end else begin
            st_v <= nx_v;
            st_p <= nx_p;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            st_rd[0] <= IssueRd;
            st_d[0]  <= IssueData;
            for (int i = 1; i < DEPTH; i++) begin
                st_rd[i] <= st_rd[i-1];
                st_d[i]  <= nx_d[i-1];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                st_d[i] <= nx_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                rf[r] <= '0;
            end
        end else if (WbValid) begin
            rf[WbRd] <= WbData;
        end
    end

    // Lowest stage index is the youngest writer, so the first hit wins.
    always_comb begin
        logic [4:0] ra;
        logic       hit;
        ra       = '0;
        hit      = 1'b0;
        RsData   = '0;
        RsHazard = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra  = RsAddr[5*k +: 5];
            hit = 1'b0;
            if (rd_ok(ra)) begin
                RsData[k*XLEN +: XLEN] = rf[ra];
                for (int i = 0; i < DEPTH; i++) begin
                    if (!hit && st_v[i] && (st_rd[i] == ra)) begin
                        hit = 1'b1;
`ifdef IEU_FWD_PIPE_BYPASS_EN
                        if (st_p[i]) begin
                            RsHazard[k] = 1'b1;
                        end else begin
                            RsData[k*XLEN +: XLEN] = st_d[i];
                        end
`else
                        RsHazard[k] = 1'b1;
`endif
                    end
                end
            end
        end
    end

endmodule
